xgmii_pack_n2w: RTL

XGMII_PACK_N2W -- requirements
Module: xgmii_pack_n2w

---
 rtl/xgmii_pack_n2w_pkg.sv | 15 +
 rtl/xgmii_sc_fifo.sv | 53 +++++
 rtl/xgmii_pack_n2w.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/xgmii_pack_n2w_pkg.sv
// rtl/xgmii_pack_n2w_pkg.sv - shared XGMII control characters and packer state type
package gtype;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

endpackage

// File: rtl/xgmii_sc_fifo.sv
// rtl/xgmii_sc_fifo.sv - single-clock first-word-fall-through FIFO
module xgmii_sc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     vld,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && ((count != CNT_FULL) || do_pop);
  assign vld     = (count != '0);
  assign head    = vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/xgmii_pack_n2w.sv
// rtl/xgmii_pack_n2w.sv - packs RATIO narrow XGMII words per wide word, frame-aware, FIFO output
module xgmii_pack_n2w
  import gtype::*;
#(
  parameter int IN_LANES = 4,
  parameter int RATIO    = 2,
  parameter int DEPTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_ena,
  input  logic [8*IN_LANES-1:0]           in_data,
  input  logic [IN_LANES-1:0]             in_ctrl,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [8*IN_LANES*RATIO-1:0]     out_data,
  output logic [IN_LANES*RATIO-1:0]       out_ctrl,
  output logic [15:0]                     frm_ok_cnt,
  output logic [15:0]                     frm_drop_cnt
);

  localparam int IW = 8 * IN_LANES;
  localparam int OW = IW * RATIO;
  localparam int CW = IN_LANES * RATIO;
  localparam int SW = (RATIO == 4) ? 2 : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [SW-1:0] SLOT_LAST = SW'(RATIO - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

  state_t         state;
  logic [SW-1:0]  slot;
  logic [OW-1:0]  acc_data;
  logic [CW-1:0]  acc_ctrl;
  logic           wr_vld;
  logic [OW-1:0]  wr_data;
  logic [CW-1:0]  wr_ctrl;
  logic [OW-1:0]  pack_data;
  logic [CW-1:0]  pack_ctrl;
  logic [OW-1:0]  flush_data;
  logic [CW-1:0]  flush_ctrl;
  logic [OW+CW-1:0] head;
  logic [AW:0]    fifo_cnt;
  logic           pop;
  logic           room;
  logic           is_start;
  logic           is_term;

  assign is_start = (in_ctrl == IN_LANES'(1)) && (in_data[7:0] == XGMII_START);

  always_comb begin
    is_term = 1'b0;
    for (int l = 0; l < IN_LANES; l++) begin
      if (in_ctrl[l] && (in_data[8*l +: 8] == XGMII_TERM)) begin
        is_term = 1'b1;
      end
    end
  end

  // pack_*: current word in its slot, idle after it; flush_*: error after the filled slots.
  always_comb begin
    pack_data  = '0;
    pack_ctrl  = '0;
    flush_data = '0;
    flush_ctrl = '0;
    for (int s = 0; s < RATIO; s++) begin
      if (s < int'(slot)) begin
        pack_data[s*IW +: IW]        = acc_data[s*IW +: IW];
        pack_ctrl[s*IN_LANES +: IN_LANES]  = acc_ctrl[s*IN_LANES +: IN_LANES];
        flush_data[s*IW +: IW]       = acc_data[s*IW +: IW];
        flush_ctrl[s*IN_LANES +: IN_LANES] = acc_ctrl[s*IN_LANES +: IN_LANES];
      end else begin
        if (s == int'(slot)) begin
          pack_data[s*IW +: IW]       = in_data;
          pack_ctrl[s*IN_LANES +: IN_LANES] = in_ctrl;
        end else begin
          pack_data[s*IW +: IW]       = {IN_LANES{XGMII_IDLE}};
          pack_ctrl[s*IN_LANES +: IN_LANES] = '1;
        end
        flush_data[s*IW +: IW]       = {IN_LANES{XGMII_ERR}};
        flush_ctrl[s*IN_LANES +: IN_LANES] = '1;
      end
    end
  end

  assign pop  = out_vld && out_rdy;
  // Space is judged including the word already staged for the FIFO.
  assign room = (int'(fifo_cnt) + int'(wr_vld) - int'(pop)) < DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      slot         <= '0;
      acc_data     <= '0;
      acc_ctrl     <= '0;
      wr_vld       <= 1'b0;
      wr_data      <= '0;
      wr_ctrl      <= '0;
      frm_ok_cnt   <= '0;
      frm_drop_cnt <= '0;
    end else begin
      wr_vld <= 1'b0;
      if (in_ena) begin
        case (state)
          ST_IDLE, ST_DROP: begin
            if (is_start) begin
              acc_data <= OW'(in_data);
              acc_ctrl <= CW'(in_ctrl);
              slot     <= SLOT_ONE;
              state    <= ST_FRAME;
            end else if (is_term) begin
              state <= ST_IDLE;
            end
          end
          ST_FRAME: begin
            if (is_start) begin
              if ((slot != '0) && room) begin
                wr_vld  <= 1'b1;
                wr_data <= flush_data;
                wr_ctrl <= flush_ctrl;
              end
              frm_drop_cnt <= frm_drop_cnt + 16'd1;
              acc_data     <= OW'(in_data);
              acc_ctrl     <= CW'(in_ctrl);
              slot         <= SLOT_ONE;
            end else if (is_term) begin
              if (room) begin
                wr_vld     <= 1'b1;
                wr_data    <= pack_data;
                wr_ctrl    <= pack_ctrl;
                frm_ok_cnt <= frm_ok_cnt + 16'd1;
              end else begin
                frm_drop_cnt <= frm_drop_cnt + 16'd1;
              end
              slot  <= '0;
              state <= ST_IDLE;
            end else begin
              acc_data <= pack_data;
              acc_ctrl <= pack_ctrl;
              if (slot == SLOT_LAST) begin
                slot <= '0;
                if (room) begin
                  wr_vld  <= 1'b1;
                  wr_data <= pack_data;
                  wr_ctrl <= pack_ctrl;
                end else begin
                  frm_drop_cnt <= frm_drop_cnt + 16'd1;
                  state        <= ST_DROP;
                end
              end else begin
                slot <= slot + SLOT_ONE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  xgmii_sc_fifo #(
    .WIDTH (OW + CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_vld),
    .push_data ({wr_ctrl, wr_data}),
    .pop       (pop),
    .head      (head),
    .vld       (out_vld),
    .count     (fifo_cnt)
  );

  assign out_ctrl = head[OW +: CW];
  assign out_data = head[OW-1:0];

endmodule
